// File: rtl/dsp48a1_pkg.sv
// Shared DSP48A1 definitions: accumulator/result widths and the
// saturation limits used when narrowing the P output.
//   CONCATENATED_SIZE : width of the DSP48A1 P output
//   OUT_SIZE          : width of the narrowed signed result
//   SAT_MAX / SAT_MIN : clamp limits for the default OUT_SIZE
//   sat_hi / sat_lo   : clamp limits for an arbitrary result width
package dsp48a1_pkg;

  localparam int CONCATENATED_SIZE = 48;
  localparam int OUT_SIZE          = 18;

  localparam logic signed [OUT_SIZE-1:0] SAT_MAX = {1'b0, {(OUT_SIZE-1){1'b1}}};
  localparam logic signed [OUT_SIZE-1:0] SAT_MIN = {1'b1, {(OUT_SIZE-1){1'b0}}};

  function automatic longint sat_hi(input int width);
    return (longint'(1) <<< (width - 1)) - 1;
  endfunction

  function automatic longint sat_lo(input int width);
    return -(longint'(1) <<< (width - 1));
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
//   clk, rst    : clock, synchronous active-high reset
//   push        : write request; push_data is stored when accepted
//   pop         : read request; ignored while empty
//   pop_data    : head entry (combinational, valid while !empty)
//   empty, full : occupancy flags
//   count       : occupied entries (0..DEPTH)
//   drop        : pulse, a push was refused because the FIFO was full
module sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 20
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           pop_data,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       drop
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push_ok;
  logic             pop_ok;

  assign empty  = (count == '0);
  assign full   = (count == CNT_W'(DEPTH));
  assign pop_ok = pop && !empty;
  // When full, a same-cycle pop frees the slot the push lands in.
  assign push_ok = push && (!full || pop_ok);
  assign drop    = push && full && !pop_ok;

  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dsp_result_packer.sv
// Narrows DSP48A1 accumulator results: round-half-up, arithmetic right
// shift by SHIFT, saturate to OUT_SIZE bits, then buffer in a FIFO with a
// valid/ready consumer side.
//   clk, RST          : clock, synchronous active-high reset
//   CE                : clock enable for the input capture register
//   P_in, CARRYOUT_in : DSP48A1 outputs, qualified by in_valid
//   out_data/out_sat/out_carry : head-of-FIFO result, zero while empty
//   out_valid, out_ready       : consumer handshake
//   fifo_count        : buffered entries
//   overflow          : sticky, a result was dropped on a full FIFO
//   sat_count         : saturating count of clamped results
//   clr_stats         : clears overflow and sat_count
module dsp_result_packer
  import dsp48a1_pkg::*;
#(
  parameter int CONCATENATED_SIZE = dsp48a1_pkg::CONCATENATED_SIZE,
  parameter int OUT_SIZE          = dsp48a1_pkg::OUT_SIZE,
  parameter int SHIFT             = 17,
  parameter int DEPTH             = 8
) (
  input  logic                          clk,
  input  logic                          RST,
  input  logic                          CE,
  input  logic [CONCATENATED_SIZE-1:0]  P_in,
  input  logic                          CARRYOUT_in,
  input  logic                          in_valid,
  output logic [OUT_SIZE-1:0]           out_data,
  output logic                          out_sat,
  output logic                          out_carry,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(DEPTH):0]        fifo_count,
  output logic                          overflow,
  output logic [15:0]                   sat_count,
  input  logic                          clr_stats
);

  localparam int EXT_W   = CONCATENATED_SIZE + 1;
  localparam int RND_W   = EXT_W - SHIFT;
  localparam int ENTRY_W = OUT_SIZE + 2;

  localparam logic signed [EXT_W-1:0] HALF_LSB = {{(EXT_W-1){1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic signed [RND_W-1:0] LIM_HI   = RND_W'(sat_hi(OUT_SIZE));
  localparam logic signed [RND_W-1:0] LIM_LO   = RND_W'(sat_lo(OUT_SIZE));

  // One extra sign bit keeps the rounding add from wrapping at the
  // positive extreme of P_in.
  logic signed [EXT_W-1:0] p_ext;
  logic signed [EXT_W-1:0] p_rounded;
  logic                    unused_round_bits;

  assign p_ext             = {P_in[CONCATENATED_SIZE-1], P_in};
  assign p_rounded         = p_ext + HALF_LSB;
  assign unused_round_bits = ^p_rounded[SHIFT-1:0];

  // Capture register. Data holds while CE=0; s1_valid marks a fresh
  // capture only, so a held value is never forwarded twice.
  logic signed [RND_W-1:0] s1_value;
  logic                    s1_carry;
  logic                    s1_valid;

  always_ff @(posedge clk) begin
    if (RST) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_carry <= 1'b0;
    end else begin
      s1_valid <= CE && in_valid;
      if (CE && in_valid) begin
        s1_value <= p_rounded[EXT_W-1:SHIFT];
        s1_carry <= CARRYOUT_in;
      end
    end
  end

  logic [OUT_SIZE-1:0] sat_data;
  logic                sat_flag;

  always_comb begin
    sat_data = s1_value[OUT_SIZE-1:0];
    sat_flag = 1'b0;
    if (s1_value > LIM_HI) begin
      sat_data = LIM_HI[OUT_SIZE-1:0];
      sat_flag = 1'b1;
    end else if (s1_value < LIM_LO) begin
      sat_data = LIM_LO[OUT_SIZE-1:0];
      sat_flag = 1'b1;
    end
  end

  // Stage result register; entry layout is {sat, carry, data}.
  logic [ENTRY_W-1:0] s2_entry;
  logic               s2_valid;

  always_ff @(posedge clk) begin
    if (RST) begin
      s2_valid <= 1'b0;
      s2_entry <= '0;
    end else begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_entry <= {sat_flag, s1_carry, sat_data};
      end
    end
  end

  logic [ENTRY_W-1:0] head;
  logic               fifo_empty;
  logic               fifo_full;
  logic               fifo_drop;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (RST),
    .push      (s2_valid),
    .push_data (s2_entry),
    .pop       (out_ready),
    .pop_data  (head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count),
    .drop      (fifo_drop)
  );

  logic unused_full;
  assign unused_full = fifo_full;

  // Memory is not reset, so the head view is forced to zero while empty.
  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head[OUT_SIZE-1:0] : '0;
  assign out_carry = out_valid ? head[OUT_SIZE]     : 1'b0;
  assign out_sat   = out_valid ? head[OUT_SIZE+1]   : 1'b0;

  logic sat_event;
  assign sat_event = s2_valid && s2_entry[OUT_SIZE+1];

  always_ff @(posedge clk) begin
    if (RST || clr_stats) begin
      overflow  <= 1'b0;
      sat_count <= '0;
    end else begin
      if (fifo_drop) overflow <= 1'b1;
      if (sat_event && (sat_count != 16'hFFFF)) begin
        sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_dsp_result_packer.sv
module tb_dsp_result_packer;

  logic        clk = 1'b0;
  logic        RST;
  logic        CE;
  logic [47:0] P_in;
  logic        CARRYOUT_in;
  logic        in_valid;
  logic [17:0] out_data;
  logic        out_sat;
  logic        out_carry;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [15:0] sat_count;
  logic        clr_stats;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dsp_result_packer #(
    .CONCATENATED_SIZE (48),
    .OUT_SIZE          (18),
    .SHIFT             (17),
    .DEPTH             (8)
  ) dut (
    .clk         (clk),
    .RST         (RST),
    .CE          (CE),
    .P_in        (P_in),
    .CARRYOUT_in (CARRYOUT_in),
    .in_valid    (in_valid),
    .out_data    (out_data),
    .out_sat     (out_sat),
    .out_carry   (out_carry),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .fifo_count  (fifo_count),
    .overflow    (overflow),
    .sat_count   (sat_count),
    .clr_stats   (clr_stats)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [47:0] p, input logic c);
    P_in        = p;
    CARRYOUT_in = c;
    in_valid    = 1'b1;
    step();
    in_valid    = 1'b0;
    CARRYOUT_in = 1'b0;
  endtask

  // Waits (bounded) for the head, checks it, and lets out_ready=1 pop it.
  task automatic expect_one(input string tag, input logic [17:0] d,
                            input logic s, input logic c);
    int n = 0;
    while (!out_valid && n < 8) begin
      step();
      n++;
    end
    chk({tag, "_vld"}, 64'(out_valid), 64'd1);
    chk({tag, "_data"}, 64'(out_data), 64'(d));
    chk({tag, "_sat"}, 64'(out_sat), 64'(s));
    chk({tag, "_carry"}, 64'(out_carry), 64'(c));
    step();
  endtask

  logic [47:0] vp [10];
  logic [17:0] vd [10];
  logic        vs [10];
  logic        vc [10];

  initial begin
    int next_exp;
    int n;

    vp[0] = 48'h0000_0000_FFFF; vd[0] = 18'h00000; vs[0] = 1'b0; vc[0] = 1'b0;
    vp[1] = 48'h0000_0001_0000; vd[1] = 18'h00001; vs[1] = 1'b0; vc[1] = 1'b0;
    vp[2] = 48'h0000_0001_8000; vd[2] = 18'h00001; vs[2] = 1'b0; vc[2] = 1'b1;
    vp[3] = 48'hFFFF_FFFF_0000; vd[3] = 18'h00000; vs[3] = 1'b0; vc[3] = 1'b0;
    vp[4] = 48'hFFFF_FFFA_0000; vd[4] = 18'h3FFFD; vs[4] = 1'b0; vc[4] = 1'b1;
    vp[5] = 48'hFFFF_FFFE_FFFF; vd[5] = 18'h3FFFF; vs[5] = 1'b0; vc[5] = 1'b0;
    vp[6] = 48'h0003_FFFE_0000; vd[6] = 18'h1FFFF; vs[6] = 1'b0; vc[6] = 1'b0;
    vp[7] = 48'h0004_0000_0000; vd[7] = 18'h1FFFF; vs[7] = 1'b1; vc[7] = 1'b0;
    vp[8] = 48'hFFFC_0000_0000; vd[8] = 18'h20000; vs[8] = 1'b0; vc[8] = 1'b0;
    vp[9] = 48'hFFFB_FFFE_FFFF; vd[9] = 18'h20000; vs[9] = 1'b1; vc[9] = 1'b1;

    RST = 1'b1; CE = 1'b1; P_in = '0; CARRYOUT_in = 1'b0; in_valid = 1'b0;
    out_ready = 1'b0; clr_stats = 1'b0;
    step();
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data), 64'd0);
    chk("rst_count", 64'(fifo_count), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    chk("rst_satcnt", 64'(sat_count), 64'd0);
    RST = 1'b0;

    // latency: capture edge k, out_valid after k+2, one cycle wide
    out_ready = 1'b1;
    send(48'h0000_0002_0000, 1'b0);
    chk("lat_k0", 64'(out_valid), 64'd0);
    step();
    chk("lat_k1", 64'(out_valid), 64'd0);
    step();
    chk("lat_k2", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'h1);
    chk("lat_sat", 64'(out_sat), 64'd0);
    chk("lat_count", 64'(fifo_count), 64'd1);
    step();
    chk("lat_k3", 64'(out_valid), 64'd0);

    for (int i = 0; i < 10; i++) begin
      send(vp[i], vc[i]);
      expect_one($sformatf("vec%0d", i), vd[i], vs[i], vc[i]);
    end
    chk("vec_satcnt", 64'(sat_count), 64'd2);

    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr1_satcnt", 64'(sat_count), 64'd0);

    send(48'h7FFF_FFFF_FFFF, 1'b0);
    expect_one("satpos", 18'h1FFFF, 1'b1, 1'b0);
    send(48'h8000_0000_0000, 1'b0);
    expect_one("satneg", 18'h20000, 1'b1, 1'b0);
    chk("sat_cnt2", 64'(sat_count), 64'd2);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("clr2_satcnt", 64'(sat_count), 64'd0);

    // CE=0 ignores in_valid
    CE = 1'b0;
    P_in = 48'h0000_0002_0000;
    in_valid = 1'b1;
    step(); step(); step();
    in_valid = 1'b0;
    CE = 1'b1;
    step(); step(); step();
    chk("ce_valid", 64'(out_valid), 64'd0);
    chk("ce_count", 64'(fifo_count), 64'd0);

    // overflow: nine inputs into a stalled FIFO
    out_ready = 1'b0;
    for (int i = 1; i <= 9; i++) send(48'(i) << 17, 1'b0);
    step(); step(); step();
    chk("ovf_count", 64'(fifo_count), 64'd8);
    chk("ovf_flag", 64'(overflow), 64'd1);
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      chk($sformatf("ovf_drain%0d", i), 64'(out_data), 64'(i));
      step();
    end
    chk("ovf_empty", 64'(out_valid), 64'd0);
    clr_stats = 1'b1;
    step();
    clr_stats = 1'b0;
    chk("ovf_clr", 64'(overflow), 64'd0);

    // full FIFO with push and pop every cycle
    out_ready = 1'b0;
    for (int t = 1; t <= 16; t++) begin
      P_in = 48'(t) << 17;
      in_valid = 1'b1;
      if (t == 11) out_ready = 1'b1;
      step();
      if (t == 10) begin
        chk("fp_count_full", 64'(fifo_count), 64'd8);
        chk("fp_head_full", 64'(out_data), 64'd1);
      end
      if (t >= 11) begin
        chk($sformatf("fp_count%0d", t), 64'(fifo_count), 64'd8);
        chk($sformatf("fp_head%0d", t), 64'(out_data), 64'(t - 9));
      end
    end
    in_valid = 1'b0;
    next_exp = 8;
    n = 0;
    while (n < 20) begin
      step();
      n++;
      if (!out_valid) break;
      chk($sformatf("fp_drain%0d", next_exp), 64'(out_data), 64'(next_exp));
      next_exp++;
    end
    chk("fp_drain_end", 64'(next_exp), 64'd17);
    chk("fp_ovf", 64'(overflow), 64'd0);

    // reset mid-operation
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) send(48'(i) << 17, 1'b1);
    step(); step(); step();
    chk("mid_count5", 64'(fifo_count), 64'd5);
    send(48'h0000_0006_0000, 1'b0);
    RST = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    step();
    RST = 1'b0;
    in_valid = 1'b0;
    chk("mid_count", 64'(fifo_count), 64'd0);
    chk("mid_valid", 64'(out_valid), 64'd0);
    chk("mid_ovf", 64'(overflow), 64'd0);
    chk("mid_data", 64'(out_data), 64'd0);
    chk("mid_carry", 64'(out_carry), 64'd0);
    step(); step(); step();
    chk("mid_flight", 64'(fifo_count), 64'd0);
    send(48'h0000_0004_0000, 1'b1);
    expect_one("post_rst", 18'h00002, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
